// File: rtl/somador_serial16.sv
// Serial adder: feeds one nibble per clock to an external somador4b, chains the carry and rebuilds the sum.
// Optional subtraction (op_sub port) is enabled by defining SOMADOR_SUBTRACAO_EN.
module somador_serial16 #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [4*NIBBLES-1:0]   op_a,
  input  logic [4*NIBBLES-1:0]   op_b,
  input  logic                   op_cin,
`ifdef SOMADOR_SUBTRACAO_EN
  input  logic                   op_sub,
`endif
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [4*NIBBLES-1:0]   sum,
  output logic                   cout,
  output logic                   busy,
  output logic [3:0]             nib_a,
  output logic [3:0]             nib_b,
  output logic                   nib_cin,
  input  logic [3:0]             nib_s,
  input  logic                   nib_cout
);

  localparam int W     = 4 * NIBBLES;
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic [W-1:0]     sum_q, sum_d;
  logic             cout_q, cout_d;
  logic [3:0]       a_sel, b_sel;
  logic [3:0]       s_fix;

  // somador4b returns its sum bit-reversed (nib_s[3] is the LSB).
  assign s_fix = {nib_s[0], nib_s[1], nib_s[2], nib_s[3]};

  always_comb begin
    a_sel = 4'd0;
    b_sel = 4'd0;
    for (int i = 0; i < NIBBLES; i++) begin
      if (idx_q == IDX_W'(i)) begin
        a_sel = a_q[4*i +: 4];
        b_sel = b_q[4*i +: 4];
      end
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign nib_a     = (state_q == CALC) ? a_sel   : 4'd0;
  assign nib_b     = (state_q == CALC) ? b_sel   : 4'd0;
  assign nib_cin   = (state_q == CALC) ? carry_q : 1'b0;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = op_a;
          b_d     = op_b;
          carry_d = op_cin;
`ifdef SOMADOR_SUBTRACAO_EN
          // Two's-complement subtract: A + ~B + 1.
          if (op_sub) begin
            b_d     = ~op_b;
            carry_d = 1'b1;
          end
`endif
          idx_d   = '0;
          sum_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        for (int i = 0; i < NIBBLES; i++) begin
          if (idx_q == IDX_W'(i)) sum_d[4*i +: 4] = s_fix;
        end
        carry_d = nib_cout;
        if (idx_q == LAST_IDX) begin
          cout_d  = nib_cout;
          idx_d   = '0;
          state_d = DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

endmodule
